// File: rtl/sysid_boot_checker.sv
// Purpose: Avalon-MM master that reads the system-ID and build-timestamp words and checks them against constants.
// Latency: with zero wait states, start sampled at edge N puts reads on the bus in cycles N+1 and N+2; done/pass are visible after edge N+3.
// Backpressure: waitrequest stalls each read with address and read held; TIMEOUT_CYCLES consecutive stalls abort to DONE with timeout set.
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1486864065,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    parameter int unsigned MAX_RETRIES        = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        mismatch,
    output logic        timeout,
    output logic [3:0]  attempts,
    output logic [31:0] captured_id,
    output logic [31:0] captured_timestamp
);

    // Limits narrowed once to the widths of the counters they are compared with.
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
    localparam logic [3:0]  RETRY_LIM   = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_ID = 3'd1,
        S_RD_TS = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        pass_q, pass_d;
    logic        mismatch_q, mismatch_d;
    logic        timeout_q, timeout_d;
    logic [3:0]  attempts_q, attempts_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [31:0] cap_id_q, cap_id_d;
    logic [31:0] cap_ts_q, cap_ts_d;

    // Stall count including the current waitrequest cycle.
    logic [15:0] wait_inc;
    logic        wait_expired;
    logic        words_match;

    assign wait_inc     = wait_cnt_q + 16'd1;
    assign wait_expired = (wait_inc == TIMEOUT_LIM);
    assign words_match  = (cap_id_q == EXPECTED_ID) && (cap_ts_q == EXPECTED_TIMESTAMP);

    // State and status registers; reset clears everything including the captured words.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pass_q     <= 1'b0;
            mismatch_q <= 1'b0;
            timeout_q  <= 1'b0;
            attempts_q <= 4'd0;
            wait_cnt_q <= 16'd0;
            cap_id_q   <= 32'd0;
            cap_ts_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            pass_q     <= pass_d;
            mismatch_q <= mismatch_d;
            timeout_q  <= timeout_d;
            attempts_q <= attempts_d;
            wait_cnt_q <= wait_cnt_d;
            cap_id_q   <= cap_id_d;
            cap_ts_q   <= cap_ts_d;
        end
    end

    // Next-state logic: read ID, read timestamp, compare, then retry or finish.
    always_comb begin
        state_d    = state_q;
        pass_d     = pass_q;
        mismatch_d = mismatch_q;
        timeout_d  = timeout_q;
        attempts_d = attempts_q;
        wait_cnt_d = wait_cnt_q;
        cap_id_d   = cap_id_q;
        cap_ts_d   = cap_ts_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // Restart from DONE behaves exactly like a first start from IDLE.
                if (start) begin
                    state_d    = S_RD_ID;
                    pass_d     = 1'b0;
                    mismatch_d = 1'b0;
                    timeout_d  = 1'b0;
                    attempts_d = 4'd0;
                    wait_cnt_d = 16'd0;
                end
            end

            S_RD_ID: begin
                if (!avm_waitrequest) begin
                    cap_id_d   = avm_readdata;
                    wait_cnt_d = 16'd0;
                    state_d    = S_RD_TS;
                end else if (wait_expired) begin
                    // A stuck slave is not retried; report and stop.
                    timeout_d  = 1'b1;
                    wait_cnt_d = 16'd0;
                    state_d    = S_DONE;
                end else begin
                    wait_cnt_d = wait_inc;
                end
            end

            S_RD_TS: begin
                if (!avm_waitrequest) begin
                    cap_ts_d   = avm_readdata;
                    // Cleared so a retry starts its first read with a fresh stall budget.
                    wait_cnt_d = 16'd0;
                    state_d    = S_CHECK;
                end else if (wait_expired) begin
                    timeout_d  = 1'b1;
                    wait_cnt_d = 16'd0;
                    state_d    = S_DONE;
                end else begin
                    wait_cnt_d = wait_inc;
                end
            end

            S_CHECK: begin
                if (words_match) begin
                    pass_d  = 1'b1;
                    state_d = S_DONE;
                end else if (attempts_q < RETRY_LIM) begin
                    attempts_d = attempts_q + 4'd1;
                    state_d    = S_RD_ID;
                end else begin
                    mismatch_d = 1'b1;
                    state_d    = S_DONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus strobes decode straight from the state register, so they only move on a
    // state change and stay stable across waitrequest stalls.
    assign avm_read    = (state_q == S_RD_ID) || (state_q == S_RD_TS);
    assign avm_address = (state_q == S_RD_TS);

    assign busy               = (state_q == S_RD_ID) || (state_q == S_RD_TS) || (state_q == S_CHECK);
    assign done               = (state_q == S_DONE);
    assign pass               = pass_q;
    assign mismatch           = mismatch_q;
    assign timeout            = timeout_q;
    assign attempts           = attempts_q;
    assign captured_id        = cap_id_q;
    assign captured_timestamp = cap_ts_q;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Purpose: directed and randomized checks of sysid_boot_checker against a read-pair reference model.
// Latency: start-to-done cycle count is predicted per run from the slave response schedule.
// Backpressure: a scripted slave inserts per-read waitrequest stalls, including stalls past the timeout.
module tb_sysid_boot_checker;

    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'd1486864065;
    localparam int          TO     = 255;
    localparam int          MAXR   = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        busy;
    logic        done;
    logic        pass;
    logic        mismatch;
    logic        timeout;
    logic [3:0]  attempts;
    logic [31:0] captured_id;
    logic [31:0] captured_timestamp;

    sysid_boot_checker dut (
        .clock              (clock),
        .reset              (reset),
        .start              (start),
        .avm_address        (avm_address),
        .avm_read           (avm_read),
        .avm_waitrequest    (avm_waitrequest),
        .avm_readdata       (avm_readdata),
        .busy               (busy),
        .done               (done),
        .pass               (pass),
        .mismatch           (mismatch),
        .timeout            (timeout),
        .attempts           (attempts),
        .captured_id        (captured_id),
        .captured_timestamp (captured_timestamp)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Slave response schedule: entry k answers the k-th read issued (even = ID, odd = timestamp).
    logic [31:0] rsp_dat  [0:7];
    int          rsp_wait [0:7];
    int          sl_idx  = 0;
    int          sl_wcnt = 0;

    // Model copies of the captured words; they persist across runs until a reset.
    logic [31:0] m_id = 32'd0;
    logic [31:0] m_ts = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave: decides each cycle's waitrequest/readdata on the falling edge from the schedule.
    always @(negedge clock) begin
        if (avm_read) begin
            if (sl_idx > 7) begin
                avm_waitrequest = 1'b1;
            end else begin
                check("slave.addr", {31'd0, avm_address}, 32'(sl_idx % 2));
                if (sl_wcnt < rsp_wait[sl_idx]) begin
                    avm_waitrequest = 1'b1;
                    avm_readdata    = $urandom;
                    sl_wcnt++;
                end else begin
                    avm_waitrequest = 1'b0;
                    avm_readdata    = rsp_dat[sl_idx];
                    sl_idx++;
                    sl_wcnt = 0;
                end
            end
        end else begin
            avm_waitrequest = 1'b0;
            avm_readdata    = $urandom;
        end
    end

    task automatic set_pair(input int p, input logic [31:0] id, input logic [31:0] ts,
                            input int wi, input int wt);
        rsp_dat[2*p]    = id;
        rsp_dat[2*p+1]  = ts;
        rsp_wait[2*p]   = wi;
        rsp_wait[2*p+1] = wt;
    endtask

    task automatic all_good();
        for (int p = 0; p < 4; p++) set_pair(p, EXP_ID, EXP_TS, 0, 0);
    endtask

    // Reference: walk read pairs; a read stalled TO or more cycles times out, otherwise
    // compare after each pair and retry up to MAXR times.
    task automatic model(output bit p, output bit m, output bit t, output int att, output int cyc);
        int k;
        bit fin;
        p = 0; m = 0; t = 0; att = 0; cyc = 0; k = 0; fin = 0;
        while (!fin) begin
            for (int w = 0; w < 2 && !fin; w++) begin
                if (rsp_wait[k] >= TO) begin
                    cyc += TO;
                    t   = 1;
                    fin = 1;
                end else begin
                    cyc += rsp_wait[k] + 1;
                    if (w == 0) m_id = rsp_dat[k];
                    else        m_ts = rsp_dat[k];
                    k++;
                end
            end
            if (!fin) begin
                cyc++;
                if (m_id == EXP_ID && m_ts == EXP_TS) begin
                    p = 1; fin = 1;
                end else if (att < MAXR) begin
                    att++;
                end else begin
                    m = 1; fin = 1;
                end
            end
        end
    endtask

    task automatic run(input string tag, input bit poke);
        bit ep, em, et;
        int eatt, ecyc, cyc;
        model(ep, em, et, eatt, ecyc);
        sl_idx  = 0;
        sl_wcnt = 0;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check({tag, ".busy"}, {31'd0, busy}, 32'd1);
        cyc = 0;
        while (!done && cyc < 3000) begin
            @(posedge clock);
            cyc++;
            @(negedge clock);
            start = (poke && cyc == 1);
        end
        start = 1'b0;
        check({tag, ".cycles"},   cyc,                      ecyc);
        check({tag, ".done"},     {31'd0, done},            32'd1);
        check({tag, ".pass"},     {31'd0, pass},            {31'd0, ep});
        check({tag, ".mismatch"}, {31'd0, mismatch},        {31'd0, em});
        check({tag, ".timeout"},  {31'd0, timeout},         {31'd0, et});
        check({tag, ".attempts"}, {28'd0, attempts},        eatt);
        check({tag, ".cap_id"},   captured_id,              m_id);
        check({tag, ".cap_ts"},   captured_timestamp,       m_ts);
        check({tag, ".read"},     {31'd0, avm_read},        32'd0);
        if (poke) begin
            repeat (3) @(negedge clock);
            check({tag, ".held_done"}, {31'd0, done}, 32'd1);
            check({tag, ".held_pass"}, {31'd0, pass}, {31'd0, ep});
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, ".read"},     {31'd0, avm_read},    32'd0);
        check({tag, ".addr"},     {31'd0, avm_address}, 32'd0);
        check({tag, ".busy"},     {31'd0, busy},        32'd0);
        check({tag, ".done"},     {31'd0, done},        32'd0);
        check({tag, ".status"},   {29'd0, pass, mismatch, timeout}, 32'd0);
        check({tag, ".attempts"}, {28'd0, attempts},    32'd0);
        check({tag, ".cap_id"},   captured_id,          32'd0);
        check({tag, ".cap_ts"},   captured_timestamp,   32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        all_good();
        repeat (3) @(negedge clock);
        check_cleared("reset");
        reset = 1'b0;

        // Nominal: both words correct, no stalls.
        all_good();
        run("t1_pass", 1'b0);

        // ID wrong on every pair: all retries used.
        for (int p = 0; p < 4; p++) set_pair(p, 32'h1, EXP_TS, 0, 0);
        run("t2_mismatch", 1'b0);

        // Timestamp wrong on the first pair only, with a few stalls.
        all_good();
        set_pair(0, EXP_ID, 32'hDEAD_BEEF, 2, 1);
        run("t3_retry", 1'b0);

        // Timestamp read never completes.
        all_good();
        set_pair(0, EXP_ID, EXP_TS, 0, 1000);
        run("t4_timeout", 1'b0);

        // Boundary: one stall short of the timeout still completes.
        all_good();
        set_pair(0, EXP_ID, EXP_TS, TO - 1, 0);
        run("t4_edge", 1'b0);

        // Start while busy is ignored; restart from DONE clears status.
        all_good();
        run("t6_poke", 1'b1);
        all_good();
        set_pair(0, 32'h5, EXP_TS, 0, 0);
        run("t6_restart", 1'b0);

        // Reset during a stalled timestamp read.
        all_good();
        set_pair(0, 32'h1234_5678, EXP_TS, 0, 40);
        sl_idx  = 0;
        sl_wcnt = 0;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (!(avm_read && avm_address) && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("t5.reach_rd_ts", {31'd0, avm_read && avm_address}, 32'd1);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_cleared("t5_reset");
        reset = 1'b0;
        m_id = 32'd0;
        m_ts = 32'd0;
        @(negedge clock);
        check_cleared("t5_idle");

        // Randomized schedules: occasional bad words and occasional stuck reads.
        for (int r = 0; r < 25; r++) begin
            for (int p = 0; p < 4; p++) begin
                set_pair(p,
                         ($urandom_range(0, 2) == 0) ? 32'($urandom) : EXP_ID,
                         ($urandom_range(0, 2) == 0) ? 32'($urandom) : EXP_TS,
                         ($urandom_range(0, 30) == 0) ? 300 : int'($urandom_range(0, 3)),
                         ($urandom_range(0, 30) == 0) ? 300 : int'($urandom_range(0, 3)));
            end
            run($sformatf("rand%0d", r), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
